// File: rtl/eq_chk_pkg.sv
// Shared types for the equivalence-check harness core.
//   state_t        : top-level sequencing states
//   side_t         : which model currently leads a lane
//   lane_status_t  : per-lane status reported to the top (occupancy,
//                    this-cycle error events, sticky lane flags)
//   stat_err_evt() : any mismatch/overflow event raised by a lane this cycle
package eq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SIDE_ILA = 1'b0,
    SIDE_HLS = 1'b1
  } side_t;

  typedef struct packed {
    logic empty;    // lane holds no buffered beats
    logic mis_evt;  // compared beats differ this cycle
    logic ovf_evt;  // beat dropped into a full lane this cycle
    logic mis;      // sticky mismatch
    logic ovf;      // sticky overflow
  } lane_status_t;

  function automatic logic stat_err_evt(input lane_status_t s);
    return s.mis_evt | s.ovf_evt;
  endfunction

endpackage

// File: rtl/eq_chk_lane.sv
// One compare lane: buffers beats of whichever model is ahead and compares
// them against the lagging model's beats, in order.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_clear           synchronous clear at the start of a new run
//   i_ila_beat/_data  ILA beat accepted this cycle and its data
//   i_hls_beat/_data  HLS beat accepted this cycle and its data
//   o_status          occupancy, error events, sticky flags
//   o_err_ila/_hls    data pair describing this cycle's error event
//                     (compared pair on mismatch, dropped beat on overflow)
module eq_chk_lane
  import eq_chk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_ila_beat,
  input  logic [DATA_W-1:0] i_ila_data,
  input  logic              i_hls_beat,
  input  logic [DATA_W-1:0] i_hls_data,
  output lane_status_t      o_status,
  output logic [DATA_W-1:0] o_err_ila,
  output logic [DATA_W-1:0] o_err_hls
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_wr;
  logic [CW-1:0]     r_cnt;
  side_t             r_side;
  logic              r_mis;
  logic              r_ovf;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_cmp;
  logic              w_ovf;
  logic              w_mis;
  side_t             w_push_side;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_cmp_ila;
  logic [DATA_W-1:0] w_cmp_hls;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == DEPTH_C);
  assign w_head  = r_mem[r_rd];

  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_cmp       = 1'b0;
    w_ovf       = 1'b0;
    w_push_side = r_side;
    w_push_data = i_ila_data;
    w_cmp_ila   = i_ila_data;
    w_cmp_hls   = i_hls_data;
    case ({i_ila_beat, i_hls_beat})
      2'b11: begin
        w_cmp = 1'b1;
        // Buffered head belongs to the leading side: it is compared with the
        // lagging side's new beat, and the leading side's new beat takes its
        // place at the tail, so occupancy and lead side stay unchanged.
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_push = 1'b1;
          if (r_side == SIDE_ILA) begin
            w_cmp_ila   = w_head;
            w_push_data = i_ila_data;
          end else begin
            w_cmp_hls   = w_head;
            w_push_data = i_hls_data;
          end
        end
      end
      2'b10: begin
        if (w_empty || (r_side == SIDE_ILA)) begin
          w_push_side = SIDE_ILA;
          w_push_data = i_ila_data;
          if (w_full) w_ovf  = 1'b1;
          else        w_push = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_cmp     = 1'b1;
          w_cmp_hls = w_head;
        end
      end
      2'b01: begin
        if (w_empty || (r_side == SIDE_HLS)) begin
          w_push_side = SIDE_HLS;
          w_push_data = i_hls_data;
          if (w_full) w_ovf  = 1'b1;
          else        w_push = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_cmp     = 1'b1;
          w_cmp_ila = w_head;
        end
      end
      default: ;
    endcase
    w_mis = w_cmp && (w_cmp_ila != w_cmp_hls);
  end

  always_comb begin
    o_err_ila = w_cmp_ila;
    o_err_hls = w_cmp_hls;
    if (w_ovf) begin
      if (w_push_side == SIDE_ILA) o_err_hls = '0;
      else                         o_err_ila = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_side <= SIDE_ILA;
      r_mis  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr   <= r_wr + 1'b1;
        r_side <= w_push_side;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_mis) r_mis <= 1'b1;
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign o_status = '{empty:   w_empty,
                      mis_evt: w_mis,
                      ovf_evt: w_ovf,
                      mis:     r_mis,
                      ovf:     r_ovf};

endmodule

// File: rtl/eq_stream_checker.sv
// Equivalence-check harness core. Sequences an ILA model and an HLS RTL model
// driven by identical stimulus, gates their clocks, and scoreboards N_CH
// output streams beat by beat (either side may lead, up to FIFO_DEPTH beats).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     pulse: IDLE/DONE -> RUN (clears previous results)
//   ila_complete/hls_complete instruction-done levels from each model
//   ila_beat/ila_data         ILA accepted beats per channel + data
//   hls_beat/hls_data         HLS accepted beats per channel + data
//   ila_step_en/hls_step_en   per-model clock enables
//   done, pass                run finished / finished with no error flags
//   mismatch, overflow,       sticky error flags
//   residue, timeout
//   err_ch, err_ila, err_hls  channel and data of the first error
//   cyc_cnt                   cycles spent in RUN (saturating)
// Build option: define EQ_CHK_STOP_ON_ERR_EN to end the run on the first
// mismatch or overflow instead of continuing to CHECK.
module eq_stream_checker
  import eq_chk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int N_CH       = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DRAIN_CYC  = 5,
  parameter int CYC_W      = 16,
  parameter int MAX_CYC    = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ila_complete,
  input  logic                   hls_complete,
  input  logic [N_CH-1:0]        ila_beat,
  input  logic [N_CH*DATA_W-1:0] ila_data,
  input  logic [N_CH-1:0]        hls_beat,
  input  logic [N_CH*DATA_W-1:0] hls_data,
  output logic                   ila_step_en,
  output logic                   hls_step_en,
  output logic                   done,
  output logic                   pass,
  output logic                   mismatch,
  output logic                   overflow,
  output logic                   residue,
  output logic                   timeout,
  output logic [$clog2(N_CH):0]  err_ch,
  output logic [DATA_W-1:0]      err_ila,
  output logic [DATA_W-1:0]      err_hls,
  output logic [CYC_W-1:0]       cyc_cnt
);

  localparam int EW = $clog2(N_CH) + 1;
  localparam int WW = $clog2(DRAIN_CYC + 2) + 1;
  localparam logic [WW-1:0]    DRAIN_C = WW'(DRAIN_CYC);
  localparam logic [CYC_W-1:0] LAST_C  = CYC_W'(MAX_CYC - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CYC_W-1:0]  r_cyc;
  logic [WW-1:0]     r_wait;
  logic              r_ila_seen;
  logic              r_res;
  logic              r_to;
  logic              r_err_seen;
  logic [EW-1:0]     r_err_ch;
  logic [DATA_W-1:0] r_err_ila;
  logic [DATA_W-1:0] r_err_hls;

  logic              w_run;
  logic              w_clear;
  lane_status_t      w_stat     [N_CH];
  logic [DATA_W-1:0] w_lane_ila [N_CH];
  logic [DATA_W-1:0] w_lane_hls [N_CH];
  logic              w_any_evt;
  logic              w_any_res;
  logic              w_mis_any;
  logic              w_ovf_any;
  logic [EW-1:0]     w_evt_ch;
  logic [EW-1:0]     w_res_ch;
  logic [DATA_W-1:0] w_evt_ila;
  logic [DATA_W-1:0] w_evt_hls;

  assign w_run   = (r_state == RUN);
  assign w_clear = start && ((r_state == IDLE) || (r_state == DONE));

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    eq_chk_lane #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_ila_beat (ila_beat[g] & w_run),
      .i_ila_data (ila_data[g*DATA_W +: DATA_W]),
      .i_hls_beat (hls_beat[g] & w_run),
      .i_hls_data (hls_data[g*DATA_W +: DATA_W]),
      .o_status   (w_stat[g]),
      .o_err_ila  (w_lane_ila[g]),
      .o_err_hls  (w_lane_hls[g])
    );
  end

  // Ascending scan with a found flag: the lowest channel wins a same-cycle tie.
  always_comb begin
    w_any_evt = 1'b0;
    w_any_res = 1'b0;
    w_mis_any = 1'b0;
    w_ovf_any = 1'b0;
    w_evt_ch  = '0;
    w_res_ch  = '0;
    w_evt_ila = '0;
    w_evt_hls = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_mis_any = w_mis_any | w_stat[c].mis;
      w_ovf_any = w_ovf_any | w_stat[c].ovf;
      if (!w_any_evt && stat_err_evt(w_stat[c])) begin
        w_any_evt = 1'b1;
        w_evt_ch  = EW'(c);
        w_evt_ila = w_lane_ila[c];
        w_evt_hls = w_lane_hls[c];
      end
      if (!w_any_res && !w_stat[c].empty) begin
        w_any_res = 1'b1;
        w_res_ch  = EW'(c);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = RUN;
      RUN: begin
        if (r_cyc == LAST_C)                          w_next = DONE;
`ifdef EQ_CHK_STOP_ON_ERR_EN
        else if (w_any_evt)                           w_next = DONE;
`endif
        else if (r_ila_seen && (r_wait > DRAIN_C))    w_next = CHECK;
      end
      CHECK: w_next = DONE;
      DONE:  if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cyc      <= '0;
      r_wait     <= '0;
      r_ila_seen <= 1'b0;
      r_res      <= 1'b0;
      r_to       <= 1'b0;
      r_err_seen <= 1'b0;
      r_err_ch   <= '0;
      r_err_ila  <= '0;
      r_err_hls  <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_cyc      <= '0;
        r_wait     <= '0;
        r_ila_seen <= 1'b0;
        r_res      <= 1'b0;
        r_to       <= 1'b0;
        r_err_seen <= 1'b0;
        r_err_ch   <= '0;
        r_err_ila  <= '0;
        r_err_hls  <= '0;
      end else begin
        case (r_state)
          RUN: begin
            if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
            if (!hls_complete)          r_wait <= '0;
            else if (r_wait <= DRAIN_C) r_wait <= r_wait + 1'b1;
            if (ila_complete)    r_ila_seen <= 1'b1;
            if (r_cyc == LAST_C) r_to       <= 1'b1;
            if (w_any_evt && !r_err_seen) begin
              r_err_seen <= 1'b1;
              r_err_ch   <= w_evt_ch;
              r_err_ila  <= w_evt_ila;
              r_err_hls  <= w_evt_hls;
            end
          end
          CHECK: begin
            if (w_any_res) begin
              r_res <= 1'b1;
              if (!r_err_seen) begin
                r_err_seen <= 1'b1;
                r_err_ch   <= w_res_ch;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ila_step_en = w_run && !ila_complete;
  assign hls_step_en = w_run && (r_wait <= DRAIN_C);
  assign done        = (r_state == DONE);
  assign mismatch    = w_mis_any;
  assign overflow    = w_ovf_any;
  assign residue     = r_res;
  assign timeout     = r_to;
  assign pass        = done && !(w_mis_any | w_ovf_any | r_res | r_to);
  assign err_ch      = r_err_ch;
  assign err_ila     = r_err_ila;
  assign err_hls     = r_err_hls;
  assign cyc_cnt     = r_cyc;

endmodule

// File: tb/tb_eq_stream_checker.sv
module tb_eq_stream_checker;

  localparam int DW    = 8;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int DRAIN = 5;
  localparam int CW    = 16;
  localparam int MAXC  = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CHECK = 2;
  localparam int M_DONE  = 3;

`ifdef EQ_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ila_complete;
  logic              hls_complete;
  logic [NCH-1:0]    ila_beat;
  logic [NCH*DW-1:0] ila_data;
  logic [NCH-1:0]    hls_beat;
  logic [NCH*DW-1:0] hls_data;
  logic              ila_step_en;
  logic              hls_step_en;
  logic              done;
  logic              pass;
  logic              mismatch;
  logic              overflow;
  logic              residue;
  logic              timeout;
  logic [1:0]        err_ch;
  logic [DW-1:0]     err_ila;
  logic [DW-1:0]     err_hls;
  logic [CW-1:0]     cyc_cnt;

  always #5 clk = ~clk;

  eq_stream_checker #(
    .DATA_W     (DW),
    .N_CH       (NCH),
    .FIFO_DEPTH (DEPTH),
    .DRAIN_CYC  (DRAIN),
    .CYC_W      (CW),
    .MAX_CYC    (MAXC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ila_complete (ila_complete),
    .hls_complete (hls_complete),
    .ila_beat     (ila_beat),
    .ila_data     (ila_data),
    .hls_beat     (hls_beat),
    .hls_data     (hls_data),
    .ila_step_en  (ila_step_en),
    .hls_step_en  (hls_step_en),
    .done         (done),
    .pass         (pass),
    .mismatch     (mismatch),
    .overflow     (overflow),
    .residue      (residue),
    .timeout      (timeout),
    .err_ch       (err_ch),
    .err_ila      (err_ila),
    .err_hls      (err_hls),
    .cyc_cnt      (cyc_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int            mst;
  int            mcyc;
  int            mwait;
  bit            mseen, mmis, movf, mres, mto, merr_seen;
  int            merr_ch, merr_ila, merr_hls;
  logic [DW-1:0] mq [NCH][$];
  bit            mlead_hls [NCH];

  task automatic model_clear();
    mcyc = 0; mwait = 0; mseen = 0;
    mmis = 0; movf = 0; mres = 0; mto = 0;
    merr_seen = 0; merr_ch = 0; merr_ila = 0; merr_hls = 0;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mlead_hls[c] = 0;
    end
  endtask

  task automatic model_step();
    int            nxt;
    bit            any_evt;
    bit            ib, hb, cmp, ovf, mis;
    logic [DW-1:0] id, hd, head;
    int            ci, ch;
    if (rst) begin
      model_clear();
      mst = M_IDLE;
      return;
    end
    case (mst)
      M_IDLE, M_DONE: begin
        if (start) begin
          model_clear();
          mst = M_RUN;
        end
      end
      M_RUN: begin
        any_evt = 0;
        for (int c = 0; c < NCH; c++) begin
          ib = ila_beat[c]; hb = hls_beat[c];
          id = ila_data[c*DW +: DW]; hd = hls_data[c*DW +: DW];
          ci = int'(id); ch = int'(hd);
          cmp = 0; ovf = 0;
          if (ib && hb) begin
            cmp = 1;
            if (mq[c].size() > 0) begin
              head = mq[c].pop_front();
              if (!mlead_hls[c]) begin ci = int'(head); mq[c].push_back(id); end
              else               begin ch = int'(head); mq[c].push_back(hd); end
            end
          end else if (ib) begin
            if (mq[c].size() == 0 || !mlead_hls[c]) begin
              if (mq[c].size() == DEPTH) begin ovf = 1; ch = 0; end
              else begin mq[c].push_back(id); mlead_hls[c] = 0; end
            end else begin
              cmp = 1; ch = int'(mq[c].pop_front());
            end
          end else if (hb) begin
            if (mq[c].size() == 0 || mlead_hls[c]) begin
              if (mq[c].size() == DEPTH) begin ovf = 1; ci = 0; end
              else begin mq[c].push_back(hd); mlead_hls[c] = 1; end
            end else begin
              cmp = 1; ci = int'(mq[c].pop_front());
            end
          end
          mis = cmp && (ci != ch);
          if (mis) mmis = 1;
          if (ovf) movf = 1;
          if ((mis || ovf) && !any_evt && !merr_seen) begin
            merr_ch = c; merr_ila = ci; merr_hls = ch;
          end
          if (mis || ovf) any_evt = 1;
        end
        if (any_evt) merr_seen = 1;
        nxt = M_RUN;
        if (mcyc == MAXC - 1) begin mto = 1; nxt = M_DONE; end
        else if (STOP_ON_ERR && any_evt) nxt = M_DONE;
        else if (mseen && mwait > DRAIN) nxt = M_CHECK;
        if (mcyc < (1 << CW) - 1) mcyc++;
        if (!hls_complete) mwait = 0;
        else if (mwait <= DRAIN) mwait++;
        if (ila_complete) mseen = 1;
        mst = nxt;
      end
      M_CHECK: begin
        for (int c = NCH - 1; c >= 0; c--) begin
          if (mq[c].size() > 0) begin
            mres = 1;
            if (!merr_seen) merr_ch = c;
          end
        end
        if (mres) merr_seen = 1;
        mst = M_DONE;
      end
      default: mst = M_IDLE;
    endcase
  endtask

  initial begin
    mst = M_IDLE;
    model_clear();
  end

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  bit e_done, e_run, e_pass;
  always @(negedge clk) begin
    if (chk_en) begin
      e_done = (mst == M_DONE);
      e_run  = (mst == M_RUN);
      e_pass = e_done && !(mmis || movf || mres || mto);
      check("done",     32'(done),        32'(e_done));
      check("pass",     32'(pass),        32'(e_pass));
      check("mismatch", 32'(mismatch),    32'(mmis));
      check("overflow", 32'(overflow),    32'(movf));
      check("residue",  32'(residue),     32'(mres));
      check("timeout",  32'(timeout),     32'(mto));
      check("err_ch",   32'(err_ch),      32'(merr_ch));
      check("err_ila",  32'(err_ila),     32'(merr_ila));
      check("err_hls",  32'(err_hls),     32'(merr_hls));
      check("cyc_cnt",  32'(cyc_cnt),     32'(mcyc));
      check("ila_en",   32'(ila_step_en), 32'(e_run && !ila_complete));
      check("hls_en",   32'(hls_step_en), 32'(e_run && (mwait <= DRAIN)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_beats();
    ila_beat = '0;
    hls_beat = '0;
    ila_data = {$urandom, $urandom};
    hls_data = {$urandom, $urandom};
  endtask

  task automatic set_beat(input bit is_ila, input int c, input logic [DW-1:0] d);
    if (is_ila) begin ila_beat[c] = 1'b1; ila_data[c*DW +: DW] = d; end
    else        begin hls_beat[c] = 1'b1; hls_data[c*DW +: DW] = d; end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: done not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic finish_run(input string name);
    clr_beats();
    ila_complete = 1'b1;
    hls_complete = 1'b1;
    wait_done(40, name);
  endtask

  task automatic idle_after();
    ila_complete = 1'b0;
    hls_complete = 1'b0;
    clr_beats();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int cnt;
  int len  [NCH];
  int ii   [NCH];
  int hi   [NCH];
  logic [DW-1:0] vals [NCH][8];
  logic [DW-1:0] d;
  int emit_cyc;
  bit early;

  initial begin
    rst = 1'b1; start = 1'b0; ila_complete = 1'b0; hls_complete = 1'b0;
    clr_beats();
    step();
    chk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_done",   32'(done),        32'd0);
    check("rst_cyc",    32'(cyc_cnt),     32'd0);
    check("rst_ila_en", 32'(ila_step_en), 32'd0);

    // T1: ILA leads by four cycles with matching data
    do_start();
    step(); step();
    set_beat(1, 0, 8'h11); step();
    clr_beats(); set_beat(1, 0, 8'h22); step();
    clr_beats(); step(); step();
    set_beat(0, 0, 8'h11); step();
    clr_beats(); set_beat(0, 0, 8'h22); step();
    finish_run("t1_wait");
    check("t1_pass",    32'(pass),    32'd1);
    check("t1_residue", 32'(residue), 32'd0);
    idle_after();

    // T2: HLS leads with 0x11, ILA answers 0x12
    do_start();
    set_beat(0, 0, 8'h11); step();
    clr_beats(); set_beat(1, 0, 8'h12); step();
    clr_beats();
    check("t2_mismatch", 32'(mismatch), 32'd1);
    check("t2_err_ila",  32'(err_ila),  32'h12);
    check("t2_err_hls",  32'(err_hls),  32'h11);
    check("t2_err_ch",   32'(err_ch),   32'd0);
    finish_run("t2_wait");
    check("t2_pass",     32'(pass),     32'd0);
    idle_after();

    // T3: five ILA beats, no HLS beats, depth four
    do_start();
    for (int k = 0; k < 5; k++) begin
      clr_beats();
      set_beat(1, 0, 8'(8'h31 + k));
      if (k == 4) check("t3_ovf_before", 32'(overflow), 32'd0);
      step();
    end
    check("t3_ovf_after", 32'(overflow), 32'd1);
    finish_run("t3_wait");
`ifndef EQ_CHK_STOP_ON_ERR_EN
    check("t3_residue", 32'(residue), 32'd1);
`endif
    check("t3_pass", 32'(pass), 32'd0);
    idle_after();

    // T4: hls_complete from RUN cycle 3 -> enable high for DRAIN+1 cycles
    do_start();
    step(); step();
    hls_complete = 1'b1;
    ila_complete = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (hls_step_en) cnt++;
      step();
    end
    check("t4_hls_en_cycles", 32'(cnt), 32'd6);
    check("t4_hls_en_end",    32'(hls_step_en), 32'd0);
    wait_done(40, "t4_wait");
    check("t4_pass", 32'(pass), 32'd1);
    idle_after();

    // T5: nothing completes -> timeout after MAX_CYC RUN cycles
    do_start();
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    check("t5_cycles",  32'(cnt),         32'd20);
    check("t5_timeout", 32'(timeout),     32'd1);
    check("t5_done",    32'(done),        32'd1);
    check("t5_cyc_cnt", 32'(cyc_cnt),     32'd20);
    check("t5_ila_en",  32'(ila_step_en), 32'd0);
    check("t5_hls_en",  32'(hls_step_en), 32'd0);
    idle_after();

    // T6: reset mid-run with two buffered beats, then a clean rerun
    do_start();
    set_beat(1, 0, 8'h41); step();
    clr_beats(); set_beat(1, 0, 8'h42); step();
    clr_beats(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_done",     32'(done),        32'd0);
    check("t6_mismatch", 32'(mismatch),    32'd0);
    check("t6_cyc",      32'(cyc_cnt),     32'd0);
    check("t6_ila_en",   32'(ila_step_en), 32'd0);
    do_start();
    set_beat(0, 0, 8'h51); step();
    clr_beats(); set_beat(1, 0, 8'h51); step();
    finish_run("t6_wait");
    check("t6_pass",     32'(pass),    32'd1);
    check("t6_residue",  32'(residue), 32'd0);
    idle_after();

    // T7: both channels mismatch in the same cycle -> channel 0 recorded
    do_start();
    set_beat(0, 0, 8'hA0); set_beat(0, 1, 8'hB0); step();
    clr_beats(); set_beat(1, 0, 8'hA1); set_beat(1, 1, 8'hB1); step();
    clr_beats();
    check("t7_err_ch",  32'(err_ch),  32'd0);
    check("t7_err_ila", 32'(err_ila), 32'hA1);
    check("t7_err_hls", 32'(err_hls), 32'hA0);
    finish_run("t7_wait");
    idle_after();

    // Randomised runs: two channels, random lead, occasional corruption
    for (int r = 0; r < 40; r++) begin
      do_start();
      for (int c = 0; c < NCH; c++) begin
        len[c] = $urandom_range(0, 5);
        ii[c] = 0;
        hi[c] = 0;
        for (int k = 0; k < 8; k++) vals[c][k] = 8'($urandom);
      end
      early    = ($urandom_range(0, 3) == 0);
      emit_cyc = ($urandom_range(0, 7) == 0) ? 14 : 8;
      for (int t = 0; t < emit_cyc; t++) begin
        clr_beats();
        for (int c = 0; c < NCH; c++) begin
          if (ii[c] < len[c] && $urandom_range(0, 3) != 0) begin
            d = vals[c][ii[c]];
            if ($urandom_range(0, 15) == 0) d = d ^ 8'h01;
            set_beat(1, c, d);
            ii[c]++;
          end
          if (hi[c] < len[c] && $urandom_range(0, 3) != 0) begin
            set_beat(0, c, vals[c][hi[c]]);
            hi[c]++;
          end
        end
        if (early && t == 3) hls_complete = 1'b1;
        if (early && t == 5) ila_complete = 1'b1;
        step();
      end
      finish_run("rand_wait");
      for (int k = 0; k < 2; k++) begin
        clr_beats();
        ila_beat = 2'($urandom);
        hls_beat = 2'($urandom);
        step();
      end
      idle_after();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
